// File: rtl/pad_window_addr_gen.sv
// pad_window_addr_gen: padded-window address generator for a KxK strided
// convolution sweep over an IMG_W x IMG_H feature map. Emits one pixel
// address plus a padding flag per kernel tap over a valid/ready stream.
// Loop order (innermost first): tap_x, tap_y, out_x, out_y.
// Optional feature macro: PADWIN_REPLICATE_EN. When defined, border taps are
// clamped to the nearest edge pixel (edge replication) and is_pad stays 0.
// When undefined, border taps report is_pad=1 with addr=0 (zero padding).
module pad_window_addr_gen #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int K      = 3,
  parameter int PAD    = 1,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 13,
  localparam int TW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              is_pad,
  output logic [TW-1:0]     tap_x,
  output logic [TW-1:0]     tap_y,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y,
  output logic              last_tap,
  output logic              last
);

  localparam int OW = (IMG_W + 2 * PAD - K) / STRIDE + 1;
  localparam int OH = (IMG_H + 2 * PAD - K) / STRIDE + 1;
  // Signed working width for input coordinates: comfortably wider than the
  // 16-bit output coordinates so the subtraction of PAD can go negative.
  localparam int CW = 34;
  localparam logic signed [CW-1:0] ZERO_S  = '0;
  localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_H);
`ifdef PADWIN_REPLICATE_EN
  localparam logic signed [CW-1:0] MAX_X_S = CW'(IMG_W - 1);
  localparam logic signed [CW-1:0] MAX_Y_S = CW'(IMG_H - 1);
`endif
  localparam logic [TW-1:0] TAP_MAX = TW'(K - 1);
  localparam logic [15:0]   OX_MAX  = 16'(OW - 1);
  localparam logic [15:0]   OY_MAX  = 16'(OH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tx_q, tx_d, ty_q, ty_d;
  logic [15:0]         ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pad_q, pad_d;
  logic                last_tap_q, last_tap_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic                load;
  logic                accept;
  logic signed [CW-1:0] ix, iy;
`ifdef PADWIN_REPLICATE_EN
  logic signed [CW-1:0] cx, cy;
`endif

  assign accept = valid_q & out_ready;

  // Next-state, counter advance and beat-load decision for the sweep FSM.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          tx_d    = '0;
          ty_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            load = 1'b1;
            if (tx_q != TAP_MAX) begin
              tx_d = tx_q + TW'(1);
            end else begin
              tx_d = '0;
              if (ty_q != TAP_MAX) begin
                ty_d = ty_q + TW'(1);
              end else begin
                ty_d = '0;
                if (ox_q != OX_MAX) begin
                  ox_d = ox_q + 16'd1;
                end else begin
                  ox_d = '0;
                  oy_d = oy_q + 16'd1;
                end
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == RUN);
  end

  // Beat fields for the counter values about to be loaded.
  always_comb begin
    ix = CW'(ox_d) * CW'(STRIDE) + CW'(tx_d) - CW'(PAD);
    iy = CW'(oy_d) * CW'(STRIDE) + CW'(ty_d) - CW'(PAD);
`ifdef PADWIN_REPLICATE_EN
    cx     = (ix < ZERO_S) ? ZERO_S : ((ix >= IMG_W_S) ? MAX_X_S : ix);
    cy     = (iy < ZERO_S) ? ZERO_S : ((iy >= IMG_H_S) ? MAX_Y_S : iy);
    pad_d  = 1'b0;
    addr_d = ADDR_W'(cy * IMG_W_S + cx);
`else
    pad_d  = (ix < ZERO_S) | (ix >= IMG_W_S) | (iy < ZERO_S) | (iy >= IMG_H_S);
    addr_d = pad_d ? '0 : ADDR_W'(iy * IMG_W_S + ix);
`endif
    last_tap_d = (tx_d == TAP_MAX) && (ty_d == TAP_MAX);
    last_d     = last_tap_d && (ox_d == OX_MAX) && (oy_d == OY_MAX);
  end

  // State, counters and registered outputs; fields only change on a load so
  // they hold steady while a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      ty_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      addr_q     <= '0;
      pad_q      <= 1'b0;
      last_tap_q <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      if (load) begin
        addr_q     <= addr_d;
        pad_q      <= pad_d;
        last_tap_q <= last_tap_d;
        last_q     <= last_d;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign addr      = addr_q;
  assign is_pad    = pad_q;
  assign tap_x     = tx_q;
  assign tap_y     = ty_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign last_tap  = last_tap_q;
  assign last      = last_q;

endmodule

// File: tb/tb_pad_window_addr_gen.sv
// Bench for pad_window_addr_gen: one default-parameter instance (A) and one
// 8x8 / K3 / PAD1 / STRIDE2 instance (B). Expected beats come from a
// closed-form model that decodes a beat index into loop coordinates.
module tb_pad_window_addr_gen;

  localparam int AW = 13;
  localparam int A_W = 64, A_H = 64, A_K = 3, A_P = 1, A_S = 1;
  localparam int B_W = 8,  B_H = 8,  B_K = 3, B_P = 1, B_S = 2;
  localparam int A_BEATS = 36864;
  localparam int B_BEATS = 144;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_start, a_ready, a_busy, a_done, a_valid, a_pad, a_lt, a_last;
  logic [AW-1:0] a_addr;
  logic [1:0]    a_tx, a_ty;
  logic [15:0]   a_ox, a_oy;
  logic          b_start, b_ready, b_busy, b_done, b_valid, b_pad, b_lt, b_last;
  logic [AW-1:0] b_addr;
  logic [1:0]    b_tx, b_ty;
  logic [15:0]   b_ox, b_oy;

  pad_window_addr_gen #(.IMG_W(A_W), .IMG_H(A_H), .K(A_K), .PAD(A_P), .STRIDE(A_S), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .out_valid(a_valid), .out_ready(a_ready), .addr(a_addr), .is_pad(a_pad),
    .tap_x(a_tx), .tap_y(a_ty), .out_x(a_ox), .out_y(a_oy),
    .last_tap(a_lt), .last(a_last));

  pad_window_addr_gen #(.IMG_W(B_W), .IMG_H(B_H), .K(B_K), .PAD(B_P), .STRIDE(B_S), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .out_valid(b_valid), .out_ready(b_ready), .addr(b_addr), .is_pad(b_pad),
    .tap_x(b_tx), .tap_y(b_ty), .out_x(b_ox), .out_y(b_oy),
    .last_tap(b_lt), .last(b_last));

  int checks = 0;
  int errors = 0;

  int a_cap_addr [A_BEATS];
  bit a_cap_pad  [A_BEATS];
  bit a_cap_last [A_BEATS];
  int b_cap_addr [B_BEATS];
  bit b_cap_pad  [B_BEATS];
  bit b_cap_last [B_BEATS];

  typedef struct {
    string name;
    bit    on_b;
    int    ox, oy, tx, ty;
    int    exp_addr;
    bit    exp_pad;
    bit    exp_last;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input bit ok, input string det);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, det);
    end
  endtask

  // Decode beat index n into its loop coordinates and derive the beat.
  task automatic model(input int w, h, k, p, s, n,
                       output int ox, oy, tx, ty, addr,
                       output bit pd, lt, lst);
    int ow, oh, ix, iy, cx, cy;
    ow = (w + 2 * p - k) / s + 1;
    oh = (h + 2 * p - k) / s + 1;
    tx = n % k;
    ty = (n / k) % k;
    ox = (n / (k * k)) % ow;
    oy = n / (k * k * ow);
    ix = ox * s + tx - p;
    iy = oy * s + ty - p;
`ifdef PADWIN_REPLICATE_EN
    cx = (ix < 0) ? 0 : ((ix >= w) ? w - 1 : ix);
    cy = (iy < 0) ? 0 : ((iy >= h) ? h - 1 : iy);
    pd = 1'b0;
    addr = (cy * w + cx) & ((1 << AW) - 1);
`else
    cx = ix;
    cy = iy;
    pd = (ix < 0) || (ix >= w) || (iy < 0) || (iy >= h);
    addr = pd ? 0 : ((cy * w + cx) & ((1 << AW) - 1));
`endif
    lt  = (tx == k - 1) && (ty == k - 1);
    lst = (n == ow * oh * k * k - 1);
  endtask

  task automatic chk_beat(input string nm, input int w, h, k, p, s, n,
                          input bit v, input int addr, input bit pd,
                          input int tx, ty, ox, oy, input bit lt, lst);
    int e_ox, e_oy, e_tx, e_ty, e_addr;
    bit e_pd, e_lt, e_lst, ok;
    model(w, h, k, p, s, n, e_ox, e_oy, e_tx, e_ty, e_addr, e_pd, e_lt, e_lst);
    ok = v && (addr == e_addr) && (pd == e_pd) && (tx == e_tx) && (ty == e_ty) &&
         (ox == e_ox) && (oy == e_oy) && (lt == e_lt) && (lst == e_lst);
    chk(nm, ok, $sformatf("beat %0d got v=%0d addr=%0d pad=%0d tap=(%0d,%0d) out=(%0d,%0d) lt=%0d last=%0d, want v=1 addr=%0d pad=%0d tap=(%0d,%0d) out=(%0d,%0d) lt=%0d last=%0d",
        n, v, addr, pd, tx, ty, ox, oy, lt, lst, e_addr, e_pd, e_tx, e_ty, e_ox, e_oy, e_lt, e_lst));
  endtask

  function automatic bit a_is_reset();
    return !a_busy && !a_done && !a_valid && a_addr == '0 && !a_pad && a_tx == '0 &&
           a_ty == '0 && a_ox == '0 && a_oy == '0 && !a_lt && !a_last;
  endfunction

  function automatic bit b_is_reset();
    return !b_busy && !b_done && !b_valid && b_addr == '0 && !b_pad && b_tx == '0 &&
           b_ty == '0 && b_ox == '0 && b_oy == '0 && !b_lt && !b_last;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard bound on total runtime.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, idx, ow, k;
    bit rdy, stalled;
    int s_addr, s_tx, s_ty, s_ox, s_oy;
    bit s_pad, s_lt, s_last;

    // Directed vectors; padding results depend on the build's border mode.
`ifdef PADWIN_REPLICATE_EN
    tbl[0] = '{"a_o00_t00",   1'b0, 0,  0,  0, 0, 0,    1'b0, 1'b0};
    tbl[4] = '{"a_o6363_t22", 1'b0, 63, 63, 2, 2, 4095, 1'b0, 1'b1};
    tbl[7] = '{"b_o00_t00",   1'b1, 0,  0,  0, 0, 0,    1'b0, 1'b0};
`else
    tbl[0] = '{"a_o00_t00",   1'b0, 0,  0,  0, 0, 0,    1'b1, 1'b0};
    tbl[4] = '{"a_o6363_t22", 1'b0, 63, 63, 2, 2, 0,    1'b1, 1'b1};
    tbl[7] = '{"b_o00_t00",   1'b1, 0,  0,  0, 0, 0,    1'b1, 1'b0};
`endif
    tbl[1] = '{"a_o00_t11",   1'b0, 0,  0,  1, 1, 0,    1'b0, 1'b0};
    tbl[2] = '{"a_o00_t22",   1'b0, 0,  0,  2, 2, 65,   1'b0, 1'b0};
    tbl[3] = '{"a_o6363_t11", 1'b0, 63, 63, 1, 1, 4095, 1'b0, 1'b0};
    tbl[5] = '{"b_o10_t01",   1'b1, 1,  0,  0, 1, 1,    1'b0, 1'b0};
    tbl[6] = '{"b_o33_t22",   1'b1, 3,  3,  2, 2, 63,   1'b0, 1'b1};

    // Reset state.
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (3) tick();
    chk("a_reset_values", a_is_reset(), $sformatf("got busy=%0d done=%0d valid=%0d addr=%0d, want all zero", a_busy, a_done, a_valid, a_addr));
    chk("b_reset_values", b_is_reset(), $sformatf("got busy=%0d done=%0d valid=%0d addr=%0d, want all zero", b_busy, b_done, b_valid, b_addr));
    // Reset wins over a coincident start.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    rst = 1'b0;
    tick();
    chk("a_reset_beats_start", !a_valid && !a_busy, $sformatf("got valid=%0d busy=%0d, want 0 0", a_valid, a_busy));
    $display("step reset: checks=%0d errors=%0d", checks, errors);

    // Full default sweep, out_ready held high.
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < A_BEATS; i++) begin
      chk_beat("a_beat", A_W, A_H, A_K, A_P, A_S, i, a_valid, int'(a_addr), a_pad,
               int'(a_tx), int'(a_ty), int'(a_ox), int'(a_oy), a_lt, a_last);
      a_cap_addr[i] = int'(a_addr);
      a_cap_pad[i]  = a_pad;
      a_cap_last[i] = a_last;
      tick();
    end
    chk("a_done_pulse", a_done && !a_valid && a_busy, $sformatf("got done=%0d valid=%0d busy=%0d, want 1 0 1", a_done, a_valid, a_busy));
    tick();
    chk("a_idle_after_done", !a_done && !a_busy && !a_valid, $sformatf("got done=%0d busy=%0d valid=%0d, want 0 0 0", a_done, a_busy, a_valid));
    $display("step default sweep: %0d beats, checks=%0d errors=%0d", A_BEATS, checks, errors);

    // B sweep with random backpressure and start pulses during RUN.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0; cyc = 0; stalled = 1'b0;
    s_addr = 0; s_tx = 0; s_ty = 0; s_ox = 0; s_oy = 0; s_pad = 0; s_lt = 0; s_last = 0;
    while (n < B_BEATS && cyc < 3000) begin
      if (stalled) begin
        chk("b_stall_stable", b_valid && int'(b_addr) == s_addr && b_pad == s_pad &&
            int'(b_tx) == s_tx && int'(b_ty) == s_ty && int'(b_ox) == s_ox &&
            int'(b_oy) == s_oy && b_lt == s_lt && b_last == s_last,
            $sformatf("beat %0d got v=%0d addr=%0d out=(%0d,%0d) tap=(%0d,%0d), want v=1 addr=%0d out=(%0d,%0d) tap=(%0d,%0d)",
                      n, b_valid, b_addr, b_ox, b_oy, b_tx, b_ty, s_addr, s_ox, s_oy, s_tx, s_ty));
      end
      rdy = 1'($urandom_range(0, 1));
      b_ready = rdy;
      b_start = ($urandom_range(0, 3) == 0);
      if (b_valid && rdy) begin
        chk_beat("b_beat", B_W, B_H, B_K, B_P, B_S, n, b_valid, int'(b_addr), b_pad,
                 int'(b_tx), int'(b_ty), int'(b_ox), int'(b_oy), b_lt, b_last);
        b_cap_addr[n] = int'(b_addr);
        b_cap_pad[n]  = b_pad;
        b_cap_last[n] = b_last;
        n++;
        stalled = 1'b0;
      end else if (b_valid) begin
        stalled = 1'b1;
        s_addr = int'(b_addr); s_pad = b_pad; s_tx = int'(b_tx); s_ty = int'(b_ty);
        s_ox = int'(b_ox); s_oy = int'(b_oy); s_lt = b_lt; s_last = b_last;
      end
      tick();
      cyc++;
    end
    b_start = 1'b0;
    b_ready = 1'b0;
    chk("b_beat_count", n == B_BEATS, $sformatf("got %0d beats in %0d cycles, want %0d", n, cyc, B_BEATS));
    chk("b_done_pulse", b_done && !b_valid, $sformatf("got done=%0d valid=%0d, want 1 0", b_done, b_valid));
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_start_at_done_ignored", !b_done && !b_busy && !b_valid, $sformatf("got done=%0d busy=%0d valid=%0d, want 0 0 0", b_done, b_busy, b_valid));
    tick();
    chk("b_stays_idle", !b_busy && !b_valid, $sformatf("got busy=%0d valid=%0d, want 0 0", b_busy, b_valid));
    $display("step backpressure sweep: %0d beats in %0d cycles, checks=%0d errors=%0d", n, cyc, checks, errors);

    // Directed table against captured beats.
    for (int i = 0; i < 8; i++) begin
      k   = tbl[i].on_b ? B_K : A_K;
      ow  = tbl[i].on_b ? (B_W + 2 * B_P - B_K) / B_S + 1 : (A_W + 2 * A_P - A_K) / A_S + 1;
      idx = ((tbl[i].oy * ow + tbl[i].ox) * k + tbl[i].ty) * k + tbl[i].tx;
      if (tbl[i].on_b) begin
        chk(tbl[i].name, b_cap_addr[idx] == tbl[i].exp_addr && b_cap_pad[idx] == tbl[i].exp_pad && b_cap_last[idx] == tbl[i].exp_last,
            $sformatf("got addr=%0d pad=%0d last=%0d, want addr=%0d pad=%0d last=%0d",
                      b_cap_addr[idx], b_cap_pad[idx], b_cap_last[idx], tbl[i].exp_addr, tbl[i].exp_pad, tbl[i].exp_last));
      end else begin
        chk(tbl[i].name, a_cap_addr[idx] == tbl[i].exp_addr && a_cap_pad[idx] == tbl[i].exp_pad && a_cap_last[idx] == tbl[i].exp_last,
            $sformatf("got addr=%0d pad=%0d last=%0d, want addr=%0d pad=%0d last=%0d",
                      a_cap_addr[idx], a_cap_pad[idx], a_cap_last[idx], tbl[i].exp_addr, tbl[i].exp_pad, tbl[i].exp_last));
      end
    end
    $display("step directed table: checks=%0d errors=%0d", checks, errors);

    // Abort a default sweep with reset at beat 100, then restart.
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (100) tick();
    chk_beat("a_beat100", A_W, A_H, A_K, A_P, A_S, 100, a_valid, int'(a_addr), a_pad,
             int'(a_tx), int'(a_ty), int'(a_ox), int'(a_oy), a_lt, a_last);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("a_abort_reset_values", a_is_reset(), $sformatf("got busy=%0d done=%0d valid=%0d addr=%0d out=(%0d,%0d) tap=(%0d,%0d), want all zero",
        a_busy, a_done, a_valid, a_addr, a_ox, a_oy, a_tx, a_ty));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_abort_no_done", !a_done && !a_valid && !a_busy, $sformatf("got done=%0d valid=%0d busy=%0d, want 0 0 0", a_done, a_valid, a_busy));
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_beat("a_restart_beat", A_W, A_H, A_K, A_P, A_S, i, a_valid, int'(a_addr), a_pad,
               int'(a_tx), int'(a_ty), int'(a_ox), int'(a_oy), a_lt, a_last);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_ready = 1'b0;
    tick();
    $display("step reset abort and restart: checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_window_addr_gen.md
# pad_window_addr_gen

Parametrised padded-window address generator for the convolution front end. It sweeps every output position of a KxK, strided convolution over an IMG_W x IMG_H feature map with PAD-pixel borders. For each kernel tap it emits one pixel-memory address plus a padding flag over a valid/ready stream. It replaces the fixed 3x3, 64-wide, counter-phase address logic with a handshaked, fully parametrised sweep that includes right and bottom border handling.

## Interface
Parameters:
- IMG_W, 64, feature-map width in pixels
- IMG_H, 64, feature-map height in pixels
- K, 3, kernel size (KxK taps, K >= 1)
- PAD, 1, zero-pad width on every side (0..K-1)
- STRIDE, 1, output stride (>= 1)
- ADDR_W, 13, address width; IMG_W*IMG_H <= 2^ADDR_W is required

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the final beat is accepted
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- addr  out  ADDR_W  row-major pixel address iy*IMG_W+ix
- is_pad  out  1  tap falls in the padding border
- tap_x, tap_y  out  clog2(K) (min 1)  kernel tap indices
- out_x, out_y  out  16  output-pixel coordinates
- last_tap  out  1  final tap (K-1,K-1) of the current output pixel
- last  out  1  final beat of the sweep

## Operation
- Output dims: OW=(IMG_W+2*PAD-K)/STRIDE+1 and OH=(IMG_H+2*PAD-K)/STRIDE+1, integer division. Beats per sweep: OW*OH*K*K.
- Loop order, innermost first: tap_x, tap_y, out_x, out_y.
- Per beat:
  - ix = out_x*STRIDE+tap_x-PAD and iy = out_y*STRIDE+tap_y-PAD, computed signed, at least 2 bits wider than the coordinates.
  - is_pad = (ix<0)|(ix>=IMG_W)|(iy<0)|(iy>=IMG_H).
  - addr = is_pad ? 0 : iy*IMG_W+ix, truncated to ADDR_W.
- FSM:
  - IDLE: start=1 moves to RUN. All counters are cleared and the first beat's fields are loaded.
  - RUN: out_valid=1. The counters advance only on out_valid&out_ready. An accepted beat with last=1 moves to DONE.
  - DONE: done=1 and out_valid=0 for one cycle, then IDLE.
- start is ignored in RUN and DONE, including start coincident with done.
- All outputs are registered. Fields are stable while out_valid&!out_ready. out_valid never drops without acceptance.
- Reset values: busy=0, done=0, out_valid=0, addr=0, is_pad=0, tap_x=tap_y=out_x=out_y=0, last_tap=0, last=0. State is IDLE.
- Reset asserted mid-sweep aborts the sweep. Reset wins over every other input in the same cycle. No done pulse is produced for an aborted sweep.

## Timing
- start high in cycle t (in IDLE): out_valid and the first beat are present from cycle t+1.
- Throughput is 1 beat/cycle with out_ready held high.
- A full default sweep with out_ready held high: beats occupy cycles t+1..t+36864, done is in cycle t+36865, IDLE from t+36866.
- done is asserted the cycle after the last beat is accepted. busy falls the cycle after done.
- A new start is accepted at the earliest one cycle after done.

## Configuration
- PADWIN_REPLICATE_EN undefined: zero padding. Border taps give is_pad=1 and addr=0.
- PADWIN_REPLICATE_EN defined: edge replication.
  - ix is clamped to [0,IMG_W-1] and iy to [0,IMG_H-1].
  - addr = clamp(iy)*IMG_W+clamp(ix).
  - is_pad is held 0 for every beat.
  - Beat count and timing are unchanged.

## Test plan
- Default parameters, start, out_ready=1, output (0,0):
  - tap(0,0) gives is_pad=1, addr=0.
  - tap(1,1) gives addr=0, is_pad=0.
  - tap(2,2) gives addr=65.
- Default sweep: exactly 36864 beats, then one done pulse.
  - Output (63,63), tap(1,1) gives addr=4095.
  - Output (63,63), tap(2,2) gives is_pad=1 with last=1.
- IMG_W=IMG_H=8, K=3, PAD=1, STRIDE=2: OW=OH=4, 144 beats.
  - Output (1,0), tap(0,1) gives ix=1, iy=0, addr=1.
  - last_tap asserts every 9th beat.
- Random out_ready backpressure at 50%:
  - fields are stable while stalled;
  - the beat sequence is identical to the out_ready=1 run;
  - start pulses issued during RUN have no effect.
- rst asserted at beat 100 of a default sweep:
  - next cycle all outputs are at reset values, with no done pulse;
  - a new start restarts from output (0,0), tap(0,0).
- With PADWIN_REPLICATE_EN:
  - output (0,0), tap(0,0) gives addr=0, is_pad=0;
  - output (63,63), tap(2,2) gives addr=4095, is_pad=0.
